// File: rtl/inv_state_machine.sv
`default_nettype none
// inv_state_machine: AES-128 InvCipher sequencer. Steps the state through ARK/ISR/ISB/IMC sub-blocks
// with a per-stage reset/enable/ready handshake and walks the round key index from 10 down to 0.
module inv_state_machine (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         En,
  input  logic [127:0] CT,
  output logic [127:0] PT,
  output logic         Ry,
  output logic [127:0] Text,
  output logic         En_ARK,
  output logic         En_ISR,
  output logic         En_ISB,
  output logic         En_IMC,
  output logic         Rst_ARK,
  output logic         Rst_ISR,
  output logic         Rst_ISB,
  output logic         Rst_IMC,
  input  logic         Ry_ARK,
  input  logic         Ry_ISR,
  input  logic         Ry_ISB,
  input  logic         Ry_IMC,
  input  logic [127:0] Text_ARK,
  input  logic [127:0] Text_ISR,
  input  logic [127:0] Text_ISB,
  input  logic [127:0] Text_IMC,
  output logic [3:0]   KeySel
);

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    ARK_R = 4'd1,
    ARK_E = 4'd2,
    ISR_R = 4'd3,
    ISR_E = 4'd4,
    ISB_R = 4'd5,
    ISB_E = 4'd6,
    IMC_R = 4'd7,
    IMC_E = 4'd8,
    DONE  = 4'd9
  } state_t;

  state_t       state;
  logic [127:0] state_reg;
  logic [127:0] pt_reg;
  logic [3:0]   round;

  logic busy;
  assign busy = (state != IDLE) && (state != DONE);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= IDLE;
      state_reg <= '0;
      pt_reg    <= '0;
      round     <= 4'd0;
    end else if (busy && !En) begin
      // abort: drop back to IDLE without touching the held plaintext
      state <= IDLE;
      round <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (En) begin
            state_reg <= CT;
            round     <= 4'd10;
            state     <= ARK_R;
          end
        end
        ARK_R: state <= ARK_E;
        ARK_E: begin
          if (Ry_ARK) begin
            state_reg <= Text_ARK;
            if (round == 4'd10) begin
              round <= 4'd9;
              state <= ISR_R;
            end else if (round == 4'd0) begin
              pt_reg <= Text_ARK;
              state  <= DONE;
            end else begin
              round <= round - 4'd1;
              state <= IMC_R;
            end
          end
        end
        ISR_R: state <= ISR_E;
        ISR_E: begin
          if (Ry_ISR) begin
            state_reg <= Text_ISR;
            state     <= ISB_R;
          end
        end
        ISB_R: state <= ISB_E;
        ISB_E: begin
          if (Ry_ISB) begin
            state_reg <= Text_ISB;
            state     <= ARK_R;
          end
        end
        IMC_R: state <= IMC_E;
        IMC_E: begin
          if (Ry_IMC) begin
            state_reg <= Text_IMC;
            state     <= ISR_R;
          end
        end
        DONE: begin
          if (!En) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic all_rst;
  assign all_rst = (state == IDLE) || (state == DONE);

  assign Rst_ARK = all_rst || (state == ARK_R);
  assign Rst_ISR = all_rst || (state == ISR_R);
  assign Rst_ISB = all_rst || (state == ISB_R);
  assign Rst_IMC = all_rst || (state == IMC_R);

  assign En_ARK = (state == ARK_E);
  assign En_ISR = (state == ISR_E);
  assign En_ISB = (state == ISB_E);
  assign En_IMC = (state == IMC_E);

  assign Ry     = (state == DONE);
  assign PT     = pt_reg;
  assign Text   = state_reg;
  assign KeySel = round;

endmodule
`default_nettype wire

// File: tb/tb_inv_state_machine.sv
`default_nettype none
// tb_inv_state_machine: directed checks of the AES-128 inverse-cipher sequencer with stub sub-blocks.
module tb_inv_state_machine;

  logic         Clk = 1'b0;
  logic         Rst, En;
  logic [127:0] CT;
  logic [127:0] PT, Text;
  logic         Ry;
  logic [3:0]   KeySel;
  logic         En_ARK, En_ISR, En_ISB, En_IMC;
  logic         Rst_ARK, Rst_ISR, Rst_ISB, Rst_IMC;
  logic         Ry_ARK, Ry_ISR, Ry_ISB, Ry_IMC;
  logic [127:0] Text_ARK, Text_ISR, Text_ISB, Text_IMC;

  inv_state_machine dut (
    .Clk(Clk), .Rst(Rst), .En(En), .CT(CT), .PT(PT), .Ry(Ry), .Text(Text),
    .En_ARK(En_ARK), .En_ISR(En_ISR), .En_ISB(En_ISB), .En_IMC(En_IMC),
    .Rst_ARK(Rst_ARK), .Rst_ISR(Rst_ISR), .Rst_ISB(Rst_ISB), .Rst_IMC(Rst_IMC),
    .Ry_ARK(Ry_ARK), .Ry_ISR(Ry_ISR), .Ry_ISB(Ry_ISB), .Ry_IMC(Ry_IMC),
    .Text_ARK(Text_ARK), .Text_ISR(Text_ISR), .Text_ISB(Text_ISB), .Text_IMC(Text_IMC),
    .KeySel(KeySel)
  );

  always #5 Clk = ~Clk;

  localparam int ARK = 0, ISR = 1, ISB = 2, IMC = 3;
  localparam logic [127:0] TAG_ARK = 128'h11000000_00000000_00000000_000000a1;
  localparam logic [127:0] TAG_ISR = 128'h00220000_00000000_00000000_0000b200;
  localparam logic [127:0] TAG_ISB = 128'h00003300_00000000_00000000_00c30000;
  localparam logic [127:0] TAG_IMC = 128'h00000044_00000000_00000000_d4000000;

  int checks = 0;
  int errors = 0;
  int mode   = 0;   // 0: zero-wait tagged, 1: delayed ready, 2: functional AES
  int stg_k  = 0;
  int seq [40];
  logic [3:0]   dcnt;
  logic [7:0]   sb  [256];
  logic [7:0]   isb [256];
  logic [31:0]  w   [44];
  logic [127:0] rk  [16];
  logic [127:0] model_pt;

  logic [8:0] ctl;
  assign ctl = {Ry, Rst_ARK, Rst_ISR, Rst_ISB, Rst_IMC, En_ARK, En_ISR, En_ISB, En_IMC};

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] fsbox(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gm(inv, x);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] f_isr(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] f_isb(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = isb[s[127-8*i -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] f_imc(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-8*(4*c)   -: 8];
      a1 = s[127-8*(4*c+1) -: 8];
      a2 = s[127-8*(4*c+2) -: 8];
      a3 = s[127-8*(4*c+3) -: 8];
      o[127-8*(4*c)   -: 8] = gm(a0, 8'd14) ^ gm(a1, 8'd11) ^ gm(a2, 8'd13) ^ gm(a3, 8'd9);
      o[127-8*(4*c+1) -: 8] = gm(a0, 8'd9)  ^ gm(a1, 8'd14) ^ gm(a2, 8'd11) ^ gm(a3, 8'd13);
      o[127-8*(4*c+2) -: 8] = gm(a0, 8'd13) ^ gm(a1, 8'd9)  ^ gm(a2, 8'd14) ^ gm(a3, 8'd11);
      o[127-8*(4*c+3) -: 8] = gm(a0, 8'd11) ^ gm(a1, 8'd13) ^ gm(a2, 8'd9)  ^ gm(a3, 8'd14);
    end
    return o;
  endfunction

  // Stub sub-blocks answering the sequencer's handshake.
  always_comb begin
    Ry_ARK = 1'b0; Ry_ISR = 1'b0; Ry_ISB = 1'b0; Ry_IMC = 1'b0;
    Text_ARK = '0; Text_ISR = '0; Text_ISB = '0; Text_IMC = '0;
    case (mode)
      0: begin
        Ry_ARK = 1'b1; Ry_ISR = 1'b1; Ry_ISB = 1'b1; Ry_IMC = 1'b1;
        Text_ARK = CT ^ {8'd1, 112'd0, 8'(stg_k + 1)};
        Text_ISR = CT ^ {8'd2, 112'd0, 8'(stg_k + 1)};
        Text_ISB = CT ^ {8'd3, 112'd0, 8'(stg_k + 1)};
        Text_IMC = CT ^ {8'd4, 112'd0, 8'(stg_k + 1)};
      end
      1: begin
        Ry_ARK = En_ARK && (dcnt == 4'd2);
        Ry_ISR = En_ISR && (dcnt == 4'd2);
        Ry_ISB = En_ISB && (dcnt == 4'd2);
        Ry_IMC = (En_IMC && (dcnt == 4'd2)) || En_ISB;
        Text_ARK = Text ^ TAG_ARK;
        Text_ISR = Text ^ TAG_ISR;
        Text_ISB = Text ^ TAG_ISB;
        Text_IMC = Text ^ TAG_IMC;
      end
      default: begin
        Ry_ARK = 1'b1; Ry_ISR = 1'b1; Ry_ISB = 1'b1; Ry_IMC = 1'b1;
        Text_ARK = Text ^ rk[KeySel];
        Text_ISR = f_isr(Text);
        Text_ISB = f_isb(Text);
        Text_IMC = f_imc(Text);
      end
    endcase
  end

  always @(posedge Clk)
    dcnt <= (En_ARK || En_ISR || En_ISB || En_IMC) ? dcnt + 4'd1 : 4'd0;

  task automatic init_model();
    logic [31:0] t;
    logic [7:0]  rc;
    int n;
    for (int i = 0; i < 256; i++) sb[i] = fsbox(8'(i));
    for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);
    w[0] = 32'h00010203; w[1] = 32'h04050607; w[2] = 32'h08090a0b; w[3] = 32'h0c0d0e0f;
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++) rk[r] = (r < 11) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
    seq[0] = ARK;
    n = 1;
    for (int r = 9; r >= 1; r--) begin
      seq[n] = ISR; seq[n+1] = ISB; seq[n+2] = ARK; seq[n+3] = IMC;
      n += 4;
    end
    seq[37] = ISR; seq[38] = ISB; seq[39] = ARK;
  endtask

  task automatic idle_cycle();
    En = 1'b0;
    @(posedge Clk); #1;
  endtask

  task automatic test_reset();
    Rst = 1'b1; En = 1'b0; CT = '0; mode = 0;
    repeat (2) @(posedge Clk);
    #1;
    Rst = 1'b0;
    checks++;
    if (ctl !== 9'b0_1111_0000) begin errors++; $display("FAIL reset_ctl got %b exp %b", ctl, 9'b0_1111_0000); end
    checks++;
    if ({PT, Text, KeySel} !== '0) begin errors++; $display("FAIL reset_data got PT=%h Text=%h KeySel=%0d exp zeros", PT, Text, KeySel); end
    model_pt = '0;
  endtask

  // Cycle-exact walk of the 40 stages with always-ready stubs; optional abort in stage abort_k.
  task automatic run_zero(input logic [127:0] c, input int abort_k);
    logic [127:0] exp_text;
    logic [3:0]   oh;
    logic [8:0]   exp_ctl;
    int rnd;
    mode = 0; CT = c; En = 1'b1; stg_k = 0;
    @(posedge Clk); #1;
    exp_text = c;
    rnd = 10;
    for (int k = 0; k < 40; k++) begin
      stg_k = k;
      for (int ph = 0; ph < 2; ph++) begin
        oh = 4'b1000 >> seq[k];
        exp_ctl = {1'b0, (ph == 0) ? oh : 4'b0000, (ph == 1) ? oh : 4'b0000};
        checks++;
        if (ctl !== exp_ctl) begin errors++; $display("FAIL zw_ctl stage=%0d ph=%0d got %b exp %b", k, ph, ctl, exp_ctl); end
        checks++;
        if (Text !== exp_text) begin errors++; $display("FAIL zw_text stage=%0d ph=%0d got %h exp %h", k, ph, Text, exp_text); end
        if (seq[k] == ARK) begin
          checks++;
          if (KeySel !== 4'(rnd)) begin errors++; $display("FAIL zw_keysel stage=%0d got %0d exp %0d", k, KeySel, rnd); end
        end
        if (k == abort_k && ph == 1) begin
          En = 1'b0;
          @(posedge Clk); #1;
          checks++;
          if (ctl !== 9'b0_1111_0000) begin errors++; $display("FAIL abort_ctl got %b exp %b", ctl, 9'b0_1111_0000); end
          checks++;
          if (PT !== model_pt) begin errors++; $display("FAIL abort_pt got %h exp %h", PT, model_pt); end
          checks++;
          if (KeySel !== 4'd0) begin errors++; $display("FAIL abort_keysel got %0d exp 0", KeySel); end
          return;
        end
        @(posedge Clk); #1;
      end
      exp_text = c ^ {8'(seq[k] + 1), 112'd0, 8'(k + 1)};
      if (seq[k] == ARK && rnd != 0) rnd--;
    end
    checks++;
    if (ctl !== 9'b1_1111_0000) begin errors++; $display("FAIL zw_done_cycle81 got %b exp %b", ctl, 9'b1_1111_0000); end
    checks++;
    if (PT !== exp_text) begin errors++; $display("FAIL zw_pt got %h exp %h", PT, exp_text); end
    model_pt = exp_text;
  endtask

  task automatic test_zero_wait();
    run_zero(128'h0123456789abcdeffedcba9876543210, -1);
    idle_cycle();
  endtask

  task automatic test_abort();
    run_zero(128'hdeadbeef_cafef00d_01020304_a5a55a5a, 17);
    run_zero(128'hdeadbeef_cafef00d_01020304_a5a55a5a, -1);
    idle_cycle();
  endtask

  task automatic test_delayed();
    logic [127:0] c;
    int cyc;
    c = 128'hfedcba98_76543210_00112233_44556677;
    mode = 1; CT = c; En = 1'b1;
    @(posedge Clk); #1;
    cyc = 1;
    while (Ry !== 1'b1 && cyc < 400) begin
      @(posedge Clk); #1;
      cyc++;
    end
    checks++;
    if (cyc != 161) begin errors++; $display("FAIL delayed_latency got %0d exp 161", cyc); end
    checks++;
    if (PT !== (c ^ TAG_ARK ^ TAG_IMC)) begin errors++; $display("FAIL delayed_pt got %h exp %h", PT, c ^ TAG_ARK ^ TAG_IMC); end
  endtask

  task automatic test_handshake_release();
    logic [127:0] c;
    c = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
    En = 1'b0;
    @(posedge Clk); #1;
    checks++;
    if (ctl !== 9'b0_1111_0000) begin errors++; $display("FAIL release_ctl got %b exp %b", ctl, 9'b0_1111_0000); end
    mode = 0; CT = c; En = 1'b1;
    @(posedge Clk); #1;
    checks++;
    if (Text !== c) begin errors++; $display("FAIL restart_text got %h exp %h", Text, c); end
    checks++;
    if (KeySel !== 4'd10 || ctl !== 9'b0_1000_0000) begin errors++; $display("FAIL restart_ark_r got KeySel=%0d ctl=%b exp 10 %b", KeySel, ctl, 9'b0_1000_0000); end
    idle_cycle();
  endtask

  task automatic test_functional();
    int cyc;
    mode = 2; CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a; En = 1'b1;
    @(posedge Clk); #1;
    cyc = 1;
    while (Ry !== 1'b1 && cyc < 200) begin
      @(posedge Clk); #1;
      cyc++;
    end
    checks++;
    if (cyc != 81) begin errors++; $display("FAIL func_latency got %0d exp 81", cyc); end
    checks++;
    if (PT !== 128'h00112233445566778899aabbccddeeff) begin errors++; $display("FAIL func_pt got %h exp %h", PT, 128'h00112233445566778899aabbccddeeff); end
    repeat (3) @(posedge Clk);
    #1;
    checks++;
    if (Ry !== 1'b1 || PT !== 128'h00112233445566778899aabbccddeeff) begin errors++; $display("FAIL func_hold got Ry=%b PT=%h", Ry, PT); end
    idle_cycle();
  endtask

  task automatic test_reset_midop();
    mode = 0; CT = 128'h13579bdf_2468ace0_0badf00d_600dcafe; En = 1'b1;
    repeat (10) @(posedge Clk);
    #1;
    Rst = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    Rst = 1'b0; En = 1'b0;
    checks++;
    if (ctl !== 9'b0_1111_0000) begin errors++; $display("FAIL midop_reset_ctl got %b exp %b", ctl, 9'b0_1111_0000); end
    checks++;
    if ({PT, Text, KeySel} !== '0) begin errors++; $display("FAIL midop_reset_data got PT=%h Text=%h KeySel=%0d exp zeros", PT, Text, KeySel); end
  endtask

  initial begin
    init_model();
    test_reset();
    test_zero_wait();
    test_abort();
    test_delayed();
    test_handshake_release();
    test_functional();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
